branch_resolve: RTL and testbench
=================================

// Module: branch_resolve
// PURPOSE
//  EX-side companion to the fetch-stage BTB. Records each fetched PC with its BTB prediction
//  (hit, target) in an in-order tracking FIFO, then pops and checks it against the resolved
//  outcome in EX. Drives BTB write-back (update_en/pc_ex/target_ex), fetch redirect and
//  pipeline flush on misprediction. Sits between EX and the BTB/IF PC mux.
// PARAMETERS
//  DEPTH        4   tracking FIFO entries (power of 2, >=2); max in-flight fetched instructions
//  RECOVER_CYC  1   cycles after a redirect during which if_push is ignored (wrong-path drain)
//  CNT_W        16  width of statistics counters
// PORTS
//  clk              in   1      clock, all state on posedge
//  rst              in   1      synchronous, active-high reset
//  if_push          in   1      fetched instruction enters pipeline; record entry
//  if_pc            in   32     PC of fetched instruction
//  if_pred_hit      in   1      BTB hit_if for if_pc (hit = predicted taken)
//  if_pred_target   in   32     BTB target_if for if_pc
//  ex_valid         in   1      instruction resolves in EX this cycle; pop head entry
//  ex_pc            in   32     PC of resolving instruction
//  ex_is_ctrl       in   1      instruction is branch/jal/jalr
//  ex_taken         in   1      resolved taken (ignored when !ex_is_ctrl)
//  ex_target        in   32     resolved target
//  fifo_full        out  1      tracking FIFO full; IF must stall
//  update_en        out  1      BTB write strobe (1-cycle pulse)
//  pc_ex            out  32     BTB write PC
//  target_ex        out  32     BTB write target
//  redirect_valid   out  1      fetch redirect / flush pulse
//  redirect_pc      out  32     correct next PC
//  err_sync         out  1      sticky: head PC != ex_pc, pop on empty, or push on full
//  ctrl_cnt         out  CNT_W  resolved control instructions, saturating
//  mispred_cnt      out  CNT_W  mispredictions, saturating
// BEHAVIOUR
//  Reset: FIFO empty, state RUN, all outputs 0 (pc_ex/target_ex/redirect_pc = 32'h0), counters 0.
//  FIFO entry {pc, hit, target}; head popped on ex_valid. Push+pop same cycle when full: legal,
//  count unchanged. Push when full w/o pop: dropped, err_sync<=1. Pop when empty: no-op,
//  err_sync<=1. Head pc != ex_pc: err_sync<=1, check still uses head prediction.
//  Check on pop (h=head.hit, t=head.target), next = ex_pc+4 (mod 2^32):
//   ctrl & taken & !h            -> mispredict, redirect ex_target, BTB update
//   ctrl & taken & h & t!=ex_target -> mispredict, redirect ex_target, BTB update
//   ctrl & !taken & h            -> mispredict, redirect next, no update
//   !ctrl & h                    -> mispredict (alias), redirect next, no update
//   otherwise                    -> correct, no outputs
//  BTB written only when entry missing or wrong; correct taken hits cause no write.
//  Latency: update_en/redirect_valid and data registered, asserted cycle N+1 for pop at N,
//  1-cycle pulses; data holds last value when strobe low.
//  FSM: RUN -> RECOVER on mispredict (edge N): FIFO cleared at that edge (including any
//   same-cycle push), counter loaded RECOVER_CYC. RECOVER: if_push ignored, ex_valid ignored,
//   decrement each cycle; ->RUN when counter reaches 0 (RECOVER_CYC=1 -> exactly 1 cycle).
//  Counters: ctrl_cnt += ex_is_ctrl on each accepted pop; mispred_cnt += 1 per mispredict;
//   both stop at all-ones. Reset mid-RECOVER returns to RUN, FIFO empty, err_sync cleared.
//  fifo_full combinational from count==DEPTH; low during reset.
// TESTING
//  T1 push pc=0x100 hit=0; pop ex_pc=0x100 ctrl taken tgt=0x200 -> next cycle update_en=1,
//     pc_ex=0x100,target_ex=0x200, redirect_valid=1 redirect_pc=0x200, mispred_cnt=1.
//  T2 push 0x100 hit=1 tgt=0x200; pop taken tgt=0x200 -> no update/redirect, ctrl_cnt=1.
//  T3 push 0x104 hit=1 tgt=0x300; pop ctrl not-taken -> redirect_pc=0x108, update_en=0;
//     with 2 younger entries queued: FIFO empty after, if_push ignored 1 cycle.
//  T4 fill 4 entries -> fifo_full=1; 5th push w/o pop -> err_sync=1; push+pop when full -> no err.
//  T5 pop on empty -> err_sync=1, no strobes; ex_pc mismatch vs head -> err_sync=1.
//  T6 ex_pc=0xFFFFFFFC non-ctrl, hit=1 -> redirect_pc=0x0; force mispred_cnt=0xFFFF -> stays.

Source files
------------

// File: rtl/branch_resolve.sv
// EX-side branch resolution: tracks fetched PCs with their BTB prediction in an in-order FIFO,
// checks each against the resolved outcome, and drives BTB write-back, fetch redirect and flush.
module branch_resolve #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned RECOVER_CYC = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_push,
  input  logic [31:0]      if_pc,
  input  logic             if_pred_hit,
  input  logic [31:0]      if_pred_target,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_is_ctrl,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             fifo_full,
  output logic             update_en,
  output logic [31:0]      pc_ex,
  output logic [31:0]      target_ex,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             err_sync,
  output logic [CNT_W-1:0] ctrl_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = (RECOVER_CYC < 2) ? 1 : $clog2(RECOVER_CYC + 1);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t           state, state_d;
  logic [RW-1:0]    rec_cnt, rec_cnt_d;
  logic [AW-1:0]    wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
  logic [CW-1:0]    count, count_d;
  logic [31:0]      mem_pc  [DEPTH];
  logic             mem_hit [DEPTH];
  logic [31:0]      mem_tgt [DEPTH];

  logic             push_ok, pop_ok;
  logic             update_en_d, redirect_valid_d, err_sync_d;
  logic [31:0]      pc_ex_d, target_ex_d, redirect_pc_d;
  logic [CNT_W-1:0] ctrl_cnt_d, mispred_cnt_d;

  logic             head_hit;
  logic [31:0]      head_pc, head_tgt, next_pc;
  logic             is_full, is_empty;

  assign head_pc  = mem_pc[rd_ptr];
  assign head_hit = mem_hit[rd_ptr];
  assign head_tgt = mem_tgt[rd_ptr];
  assign next_pc  = ex_pc + 32'd4;
  assign is_full  = (count == CW'(DEPTH));
  assign is_empty = (count == '0);

  assign fifo_full = is_full && !rst;

  // Next-state, FIFO bookkeeping, prediction check and registered strobes
  always_comb begin
    state_d          = state;
    rec_cnt_d        = rec_cnt;
    wr_ptr_d         = wr_ptr;
    rd_ptr_d         = rd_ptr;
    count_d          = count;
    push_ok          = 1'b0;
    pop_ok           = 1'b0;
    update_en_d      = 1'b0;
    redirect_valid_d = 1'b0;
    pc_ex_d          = pc_ex;
    target_ex_d      = target_ex;
    redirect_pc_d    = redirect_pc;
    err_sync_d       = err_sync;
    ctrl_cnt_d       = ctrl_cnt;
    mispred_cnt_d    = mispred_cnt;

    case (state)
      RUN: begin
        pop_ok  = ex_valid && !is_empty;
        push_ok = if_push && (!is_full || pop_ok);
        if (ex_valid && is_empty) err_sync_d = 1'b1;
        if (if_push && is_full && !pop_ok) err_sync_d = 1'b1;

        if (pop_ok) begin
          if (head_pc != ex_pc) err_sync_d = 1'b1;
          if (ex_is_ctrl && (ctrl_cnt != '1)) ctrl_cnt_d = ctrl_cnt + CNT_W'(1);

          // Taken but missing/wrong in BTB: redirect to target and write the BTB
          if (ex_is_ctrl && ex_taken && (!head_hit || (head_tgt != ex_target))) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = ex_target;
            update_en_d      = 1'b1;
            pc_ex_d          = ex_pc;
            target_ex_d      = ex_target;
          end else if (head_hit && !(ex_is_ctrl && ex_taken)) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = next_pc;
          end
        end

        if (redirect_valid_d) begin
          state_d   = RECOVER;
          rec_cnt_d = RW'(RECOVER_CYC);
          if (mispred_cnt != '1) mispred_cnt_d = mispred_cnt + CNT_W'(1);
          push_ok   = 1'b0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          count_d   = '0;
        end else begin
          if (push_ok) wr_ptr_d = wr_ptr + AW'(1);
          if (pop_ok)  rd_ptr_d = rd_ptr + AW'(1);
          count_d = count + CW'(push_ok) - CW'(pop_ok);
        end
      end

      RECOVER: begin
        rec_cnt_d = rec_cnt - RW'(1);
        if (rec_cnt <= RW'(1)) state_d = RUN;
      end

      default: state_d = RUN;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      rec_cnt        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      update_en      <= 1'b0;
      redirect_valid <= 1'b0;
      pc_ex          <= 32'h0;
      target_ex      <= 32'h0;
      redirect_pc    <= 32'h0;
      err_sync       <= 1'b0;
      ctrl_cnt       <= '0;
      mispred_cnt    <= '0;
    end else begin
      state          <= state_d;
      rec_cnt        <= rec_cnt_d;
      wr_ptr         <= wr_ptr_d;
      rd_ptr         <= rd_ptr_d;
      count          <= count_d;
      update_en      <= update_en_d;
      redirect_valid <= redirect_valid_d;
      pc_ex          <= pc_ex_d;
      target_ex      <= target_ex_d;
      redirect_pc    <= redirect_pc_d;
      err_sync       <= err_sync_d;
      ctrl_cnt       <= ctrl_cnt_d;
      mispred_cnt    <= mispred_cnt_d;
    end
  end

  // Tracking storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_pc[wr_ptr]  <= if_pc;
      mem_hit[wr_ptr] <= if_pred_hit;
      mem_tgt[wr_ptr] <= if_pred_target;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed, table-driven bench for branch_resolve with a narrow-counter instance for saturation.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_push, if_pred_hit, ex_valid, ex_is_ctrl, ex_taken;
  logic [31:0] if_pc, if_pred_target, ex_pc, ex_target;
  logic        fifo_full, update_en, redirect_valid, err_sync;
  logic [31:0] pc_ex, target_ex, redirect_pc;
  logic [15:0] ctrl_cnt, mispred_cnt;

  logic        s_full, s_upd, s_red, s_err;
  logic [31:0] s_pc_ex, s_tgt_ex, s_rpc;
  logic [1:0]  s_ctrl_cnt, s_mis_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve #(.DEPTH(4), .RECOVER_CYC(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_push(if_push), .if_pc(if_pc), .if_pred_hit(if_pred_hit),
    .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_ctrl(ex_is_ctrl),
    .ex_taken(ex_taken), .ex_target(ex_target), .fifo_full(fifo_full), .update_en(update_en),
    .pc_ex(pc_ex), .target_ex(target_ex), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .err_sync(err_sync), .ctrl_cnt(ctrl_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_resolve #(.DEPTH(4), .RECOVER_CYC(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .if_push(if_push), .if_pc(if_pc), .if_pred_hit(if_pred_hit),
    .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_ctrl(ex_is_ctrl),
    .ex_taken(ex_taken), .ex_target(ex_target), .fifo_full(s_full), .update_en(s_upd),
    .pc_ex(s_pc_ex), .target_ex(s_tgt_ex), .redirect_valid(s_red),
    .redirect_pc(s_rpc), .err_sync(s_err), .ctrl_cnt(s_ctrl_cnt), .mispred_cnt(s_mis_cnt)
  );

  typedef struct {
    logic        rst, push;
    logic [31:0] pc;
    logic        hit;
    logic [31:0] tgt;
    logic        exv;
    logic [31:0] expc;
    logic        ctrl, taken;
    logic [31:0] extgt;
    logic        upd, red;
    logic [31:0] rpc, pcex, tgex;
    logic        full, err;
    logic [15:0] cc, mc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t stim(logic r, logic p, logic [31:0] pc, logic h, logic [31:0] t,
                                logic v, logic [31:0] epc, logic c, logic tk, logic [31:0] et);
    vec_t x;
    x.rst = r; x.push = p; x.pc = pc; x.hit = h; x.tgt = t;
    x.exv = v; x.expc = epc; x.ctrl = c; x.taken = tk; x.extgt = et;
    x.upd = 0; x.red = 0; x.rpc = 0; x.pcex = 0; x.tgex = 0; x.full = 0; x.err = 0;
    x.cc = 0; x.mc = 0;
    return x;
  endfunction

  task automatic add(vec_t s, logic u, logic rd, logic [31:0] rp, logic [31:0] pe,
                     logic [31:0] te, logic f, logic e, logic [15:0] c, logic [15:0] m);
    s.upd = u; s.red = rd; s.rpc = rp; s.pcex = pe; s.tgex = te;
    s.full = f; s.err = e; s.cc = c; s.mc = m;
    vecs.push_back(s);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t s);
    rst = s.rst; if_push = s.push; if_pc = s.pc; if_pred_hit = s.hit; if_pred_target = s.tgt;
    ex_valid = s.exv; ex_pc = s.expc; ex_is_ctrl = s.ctrl; ex_taken = s.taken; ex_target = s.extgt;
  endtask

  task automatic idle();
    drive(stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1: miss on taken branch
    add(stim(0,1,32'h100,0,0, 0,0,0,0,0),                    0,0,32'h0,  32'h0,  32'h0,  0,0,0,0);
    add(stim(0,0,0,0,0, 1,32'h100,1,1,32'h200),              1,1,32'h200,32'h100,32'h200,0,0,1,1);
    add(stim(0,0,0,0,0, 0,0,0,0,0),                          0,0,32'h200,32'h100,32'h200,0,0,1,1);
    // T2: correct taken hit
    add(stim(0,1,32'h100,1,32'h200, 0,0,0,0,0),              0,0,32'h200,32'h100,32'h200,0,0,1,1);
    add(stim(0,0,0,0,0, 1,32'h100,1,1,32'h200),              0,0,32'h200,32'h100,32'h200,0,0,2,1);
    // T3: predicted-taken branch falls through with younger entries queued
    add(stim(0,1,32'h104,1,32'h300, 0,0,0,0,0),              0,0,32'h200,32'h100,32'h200,0,0,2,1);
    add(stim(0,1,32'h108,0,0, 0,0,0,0,0),                    0,0,32'h200,32'h100,32'h200,0,0,2,1);
    add(stim(0,1,32'h10c,0,0, 1,32'h104,1,0,0),              0,1,32'h108,32'h100,32'h200,0,0,3,2);
    add(stim(0,1,32'h200,0,0, 1,32'h108,1,1,32'h999),        0,0,32'h108,32'h100,32'h200,0,0,3,2);
    add(stim(0,0,0,0,0, 1,32'h200,0,0,0),                    0,0,32'h108,32'h100,32'h200,0,1,3,2);
    add(stim(1,0,0,0,0, 0,0,0,0,0),                          0,0,32'h0,  32'h0,  32'h0,  0,0,0,0);
    // T4: fill, push+pop while full, overflow
    add(stim(0,1,32'h10,0,0, 0,0,0,0,0),                     0,0,0,0,0,0,0,0,0);
    add(stim(0,1,32'h14,0,0, 0,0,0,0,0),                     0,0,0,0,0,0,0,0,0);
    add(stim(0,1,32'h18,0,0, 0,0,0,0,0),                     0,0,0,0,0,0,0,0,0);
    add(stim(0,1,32'h1c,0,0, 0,0,0,0,0),                     0,0,0,0,0,1,0,0,0);
    add(stim(0,1,32'h20,0,0, 1,32'h10,0,0,0),                0,0,0,0,0,1,0,0,0);
    add(stim(0,1,32'h24,0,0, 0,0,0,0,0),                     0,0,0,0,0,1,1,0,0);
    add(stim(0,0,0,0,0, 1,32'h14,0,0,0),                     0,0,0,0,0,0,1,0,0);
    add(stim(0,0,0,0,0, 1,32'h18,0,0,0),                     0,0,0,0,0,0,1,0,0);
    add(stim(0,0,0,0,0, 1,32'h1c,0,0,0),                     0,0,0,0,0,0,1,0,0);
    add(stim(0,0,0,0,0, 1,32'h20,0,0,0),                     0,0,0,0,0,0,1,0,0);
    add(stim(1,0,0,0,0, 0,0,0,0,0),                          0,0,0,0,0,0,0,0,0);
    // T5: pop on empty, then head PC mismatch
    add(stim(0,0,0,0,0, 1,32'h50,0,0,0),                     0,0,0,0,0,0,1,0,0);
    add(stim(1,0,0,0,0, 0,0,0,0,0),                          0,0,0,0,0,0,0,0,0);
    add(stim(0,1,32'h40,0,0, 0,0,0,0,0),                     0,0,0,0,0,0,0,0,0);
    add(stim(0,0,0,0,0, 1,32'h44,0,0,0),                     0,0,0,0,0,0,1,0,0);
    add(stim(1,0,0,0,0, 0,0,0,0,0),                          0,0,0,0,0,0,0,0,0);
    // T6: alias hit at top of address space wraps to 0; wrong-target hit
    add(stim(0,1,32'h500,0,0, 0,0,0,0,0),                    0,0,0,0,0,0,0,0,0);
    add(stim(0,0,0,0,0, 1,32'h500,1,1,32'h600),              1,1,32'h600,32'h500,32'h600,0,0,1,1);
    add(stim(0,0,0,0,0, 0,0,0,0,0),                          0,0,32'h600,32'h500,32'h600,0,0,1,1);
    add(stim(0,1,32'hFFFFFFFC,1,32'h1234, 0,0,0,0,0),        0,0,32'h600,32'h500,32'h600,0,0,1,1);
    add(stim(0,0,0,0,0, 1,32'hFFFFFFFC,0,0,0),               0,1,32'h0,  32'h500,32'h600,0,0,1,2);
    add(stim(0,0,0,0,0, 0,0,0,0,0),                          0,0,32'h0,  32'h500,32'h600,0,0,1,2);
    add(stim(0,1,32'h700,1,32'h800, 0,0,0,0,0),              0,0,32'h0,  32'h500,32'h600,0,0,1,2);
    add(stim(0,0,0,0,0, 1,32'h700,1,1,32'h900),              1,1,32'h900,32'h700,32'h900,0,0,2,3);
    add(stim(0,0,0,0,0, 0,0,0,0,0),                          0,0,32'h900,32'h700,32'h900,0,0,2,3);

    idle();
    rst = 1'b1;
    repeat (2) tick();
    chk("reset fifo_full", 32'(fifo_full), 32'h0);
    chk("reset update_en", 32'(update_en), 32'h0);
    chk("reset redirect_valid", 32'(redirect_valid), 32'h0);
    chk("reset redirect_pc", redirect_pc, 32'h0);
    chk("reset err_sync", 32'(err_sync), 32'h0);
    chk("reset mispred_cnt", 32'(mispred_cnt), 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      tick();
      chk($sformatf("row%0d update_en", i), 32'(update_en), 32'(vecs[i].upd));
      chk($sformatf("row%0d redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].red));
      chk($sformatf("row%0d redirect_pc", i), redirect_pc, vecs[i].rpc);
      chk($sformatf("row%0d pc_ex", i), pc_ex, vecs[i].pcex);
      chk($sformatf("row%0d target_ex", i), target_ex, vecs[i].tgex);
      chk($sformatf("row%0d fifo_full", i), 32'(fifo_full), 32'(vecs[i].full));
      chk($sformatf("row%0d err_sync", i), 32'(err_sync), 32'(vecs[i].err));
      chk($sformatf("row%0d ctrl_cnt", i), 32'(ctrl_cnt), 32'(vecs[i].cc));
      chk($sformatf("row%0d mispred_cnt", i), 32'(mispred_cnt), 32'(vecs[i].mc));
    end

    // fifo_full is forced low combinationally while reset is asserted
    for (int i = 0; i < 4; i++) begin
      drive(stim(0, 1, 32'h3000 + 32'(i * 4), 0, 0, 0, 0, 0, 0, 0));
      tick();
    end
    idle();
    chk("full before reset", 32'(fifo_full), 32'h1);
    rst = 1'b1;
    #1;
    chk("full during reset", 32'(fifo_full), 32'h0);
    tick();
    chk("full after reset edge", 32'(fifo_full), 32'h0);
    rst = 1'b0;

    // Saturation on the 2-bit counter instance
    for (int i = 1; i <= 4; i++) begin
      drive(stim(0, 1, 32'h1000 + 32'(i * 16), 0, 0, 0, 0, 0, 0, 0));
      tick();
      drive(stim(0, 0, 0, 0, 0, 1, 32'h1000 + 32'(i * 16), 1, 1, 32'h2000));
      tick();
      chk($sformatf("sat%0d redirect_valid", i), 32'(s_red), 32'h1);
      chk($sformatf("sat%0d mispred_cnt", i), 32'(s_mis_cnt), (i > 3) ? 32'd3 : 32'(i));
      chk($sformatf("sat%0d ctrl_cnt", i), 32'(s_ctrl_cnt), (i > 3) ? 32'd3 : 32'(i));
      idle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
